// File: rtl/average_accumulator.sv
// Global-average stage: accumulates 9-lane RAM samples per channel group over 4096
// samples, then emits rounded (half-up) averages over a valid/ready handshake.
module average_accumulator #(
    parameter int DATA_W = 16,
    parameter int LANES  = 9,
    parameter int SHIFT  = 12,
    parameter int ACC_W  = DATA_W + SHIFT
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_resetAverage,
    input  logic                    i_writeEnable,
    input  logic                    i_mask,
    input  logic                    i_finish,
    input  logic [LANES*DATA_W-1:0] i_data0,
    input  logic [LANES*DATA_W-1:0] i_data1,
    input  logic [LANES*DATA_W-1:0] i_data2,
    output logic [DATA_W-1:0]       o_average0,
    output logic [DATA_W-1:0]       o_average1,
    output logic [DATA_W-1:0]       o_average2,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [SHIFT:0]          o_count,
    output logic                    o_error
);
    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, DIVIDE, HOLD} state_t;

    localparam logic [SHIFT:0] FULL_COUNT = {1'b1, {SHIFT{1'b0}}};
    localparam logic [SHIFT:0] INC_FULL   = (SHIFT+1)'(LANES);
    localparam logic [ACC_W:0] HALF       = (ACC_W+1)'(1) << (SHIFT-1);

    state_t                    state_q, state_d;
    logic [LANES*DATA_W-1:0]   data [3];
    logic [ACC_W-1:0]          sum_d [3];
    logic [ACC_W-1:0]          s_q [3], s_d [3];
    logic [ACC_W-1:0]          acc_q [3], acc_d [3];
    logic [DATA_W-1:0]         avg_q [3], avg_d [3];
    logic                      pend_q, pend_d;
    logic                      valid_q, valid_d;
    logic                      err_q, err_d;
    logic [SHIFT:0]            cnt_q, cnt_d;
    logic                      we_ok;
    logic signed [DATA_W-1:0]  lane;
    logic signed [ACC_W-1:0]   lane_ext;
    logic [ACC_W:0]            rnd;

    assign data[0] = i_data0;
    assign data[1] = i_data1;
    assign data[2] = i_data2;

    assign we_ok = i_writeEnable && i_resetAverage && (state_q inside {IDLE, ACCUM, HOLD});

    // Masked lanes (1..LANES-1 when i_mask=0) contribute nothing to the group sum.
    always_comb begin
        lane     = '0;
        lane_ext = '0;
        for (int unsigned g = 0; g < 3; g++) begin
            sum_d[g] = '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                lane     = data[g][k*DATA_W +: DATA_W];
                lane_ext = lane;
                if (i_mask || k == 0) sum_d[g] = sum_d[g] + lane_ext;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rnd     = '0;
        for (int unsigned g = 0; g < 3; g++) begin
            s_d[g]   = s_q[g];
            acc_d[g] = acc_q[g];
            avg_d[g] = avg_q[g];
        end

        if (pend_q) begin
            for (int unsigned g = 0; g < 3; g++) acc_d[g] = acc_q[g] + s_q[g];
            pend_d = 1'b0;
        end
        if (we_ok) begin
            for (int unsigned g = 0; g < 3; g++) s_d[g] = sum_d[g];
            pend_d = 1'b1;
            cnt_d  = cnt_q + (i_mask ? INC_FULL : (SHIFT+1)'(1));
        end

        case (state_q)
            IDLE:  if (we_ok) state_d = ACCUM;
            ACCUM: if (i_finish) state_d = DRAIN;
            DRAIN: begin
                if (i_writeEnable || i_finish) err_d = 1'b1;
                if (!pend_q) begin
                    state_d = DIVIDE;
                    if (cnt_q != FULL_COUNT) err_d = 1'b1;
                end
            end
            DIVIDE: begin
                if (i_writeEnable || i_finish) err_d = 1'b1;
                for (int unsigned g = 0; g < 3; g++) begin
                    rnd      = {acc_q[g][ACC_W-1], acc_q[g]} + HALF;
                    avg_d[g] = rnd[SHIFT +: DATA_W];
                end
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (i_finish) err_d = 1'b1;
                if (valid_q && i_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pass clear: HOLD keeps its pending result and handshake untouched.
        if (!i_resetAverage) begin
            for (int unsigned g = 0; g < 3; g++) begin
                s_d[g]   = '0;
                acc_d[g] = '0;
                avg_d[g] = avg_q[g];
            end
            pend_d = 1'b0;
            cnt_d  = '0;
            err_d  = 1'b0;
            if (state_q != HOLD) begin
                state_d = IDLE;
                valid_d = valid_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            for (int unsigned g = 0; g < 3; g++) begin
                s_q[g]   <= '0;
                acc_q[g] <= '0;
                avg_q[g] <= '0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            for (int unsigned g = 0; g < 3; g++) begin
                s_q[g]   <= s_d[g];
                acc_q[g] <= acc_d[g];
                avg_q[g] <= avg_d[g];
            end
        end
    end

    assign o_average0 = avg_q[0];
    assign o_average1 = avg_q[1];
    assign o_average2 = avg_q[2];
    assign o_valid    = valid_q;
    assign o_count    = cnt_q;
    assign o_error    = err_q;
endmodule
